// File: rtl/dequant_unpacker.sv
// Widens packed signed lanes to INPUT_BW, scales by 2^shift and saturates, one lane per beat.
// Optional sticky clamp flag output sat_seen when DEQUANT_SAT_FLAG_EN is defined.
module dequant_unpacker #(
    parameter int INPUT_BW  = 32,
    parameter int TARGET_BW = 8,
    parameter int LANES     = 4,
    parameter int SHIFT_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*TARGET_BW-1:0] in_data,
    input  logic [SHIFT_W-1:0]         in_shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INPUT_BW-1:0]        out_data,
    output logic [$clog2(LANES)-1:0]   out_lane,
`ifdef DEQUANT_SAT_FLAG_EN
    output logic                       sat_seen,
`endif
    output logic                       out_last
);

    localparam int LW  = $clog2(LANES);
    localparam int EW0 = TARGET_BW + (1 << SHIFT_W);
    // Intermediate must hold the largest shifted lane exactly
    localparam int EW  = (EW0 > INPUT_BW) ? EW0 : INPUT_BW + 1;
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);
    localparam logic signed [EW-1:0] MAXV =
        {{(EW-INPUT_BW+1){1'b0}}, {(INPUT_BW-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV =
        {{(EW-INPUT_BW+1){1'b1}}, {(INPUT_BW-1){1'b0}}};

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                     state_q, state_d;
    logic [LANES*TARGET_BW-1:0] buf_q, buf_d;
    logic [SHIFT_W-1:0]         shift_q, shift_d;
    logic [LW-1:0]              lane_q, lane_d;
    logic                       accept, beat, at_last;
    logic signed [TARGET_BW-1:0] lane_v;
    logic signed [EW-1:0]       wide, scaled;
    logic                       over, under;

    assign at_last   = (lane_q == LAST);
    assign out_valid = (state_q == EMIT);
    assign beat      = out_valid & out_ready;
    assign in_ready  = ~rst & ((state_q == IDLE) | (beat & at_last));
    assign accept    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            shift_q <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            shift_q <= shift_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        shift_d = shift_q;
        lane_d  = lane_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d   = in_data;
                    shift_d = in_shift;
                    lane_d  = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (beat) begin
                    if (!at_last) begin
                        lane_d = lane_q + LW'(1);
                    end else if (accept) begin
                        buf_d   = in_data;
                        shift_d = in_shift;
                        lane_d  = '0;
                    end else begin
                        lane_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lane_v = buf_q[TARGET_BW-1:0];
        for (int k = 1; k < LANES; k++) begin
            if (lane_q == LW'(k)) lane_v = buf_q[k*TARGET_BW +: TARGET_BW];
        end
    end

    assign wide     = EW'(lane_v);
    assign scaled   = wide <<< shift_q;
    assign over     = (scaled > MAXV);
    assign under    = (scaled < MINV);
    assign out_data = over  ? MAXV[INPUT_BW-1:0] :
                      under ? MINV[INPUT_BW-1:0] :
                              scaled[INPUT_BW-1:0];
    assign out_lane = lane_q;
    assign out_last = at_last & out_valid;

`ifdef DEQUANT_SAT_FLAG_EN
    logic sat_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       sat_q <= 1'b0;
        else if (beat & (over | under)) sat_q <= 1'b1;
    end
    assign sat_seen = sat_q;
`endif

endmodule

// File: tb/tb_dequant_unpacker.sv
// Bench for dequant_unpacker: 32-bit and 12-bit instances share stimulus.
// Table vectors, directed corner sequences and a randomized scoreboard run.
module tb_dequant_unpacker;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shift;
    logic        rdy32, rdy12, v32, v12, last32, last12;
    logic [31:0] d32;
    logic [11:0] d12;
    logic [1:0]  lane32, lane12;
`ifdef DEQUANT_SAT_FLAG_EN
    logic        sat32, sat12;
`endif
    bit          se32, se12;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dequant_unpacker #(.INPUT_BW(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_data(in_data), .in_shift(in_shift), .out_valid(v32),
        .out_ready(out_ready), .out_data(d32), .out_lane(lane32),
`ifdef DEQUANT_SAT_FLAG_EN
        .sat_seen(sat32),
`endif
        .out_last(last32)
    );

    dequant_unpacker #(.INPUT_BW(12)) dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy12),
        .in_data(in_data), .in_shift(in_shift), .out_valid(v12),
        .out_ready(out_ready), .out_data(d12), .out_lane(lane12),
`ifdef DEQUANT_SAT_FLAG_EN
        .sat_seen(sat12),
`endif
        .out_last(last12)
    );

    typedef struct packed {
        logic [31:0]       data;
        logic [4:0]        sh;
        logic [3:0][31:0]  e32;
        logic [3:0][11:0]  e12;
    } vec_t;

    typedef struct {
        longint a;
        longint b;
        int     lane;
        bit     ca;
        bit     cb;
    } exp_t;

    vec_t tv[6];
    exp_t q[$];

    function automatic longint ref_lane(int bw, logic [7:0] b, int sh,
                                        output bit clamped);
        longint v  = longint'(signed'(b));
        longint r  = v * (longint'(1) << sh);
        longint hi = (longint'(1) << (bw - 1)) - 1;
        longint lo = -(longint'(1) << (bw - 1));
        clamped = 1'b0;
        if (r > hi) begin
            clamped = 1'b1;
            return hi;
        end
        if (r < lo) begin
            clamped = 1'b1;
            return lo;
        end
        return r;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sat(string tag);
`ifdef DEQUANT_SAT_FLAG_EN
        chk({tag, ".sat32"}, longint'(sat32), longint'(se32));
        chk({tag, ".sat12"}, longint'(sat12), longint'(se12));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    task automatic check_beat(string tag, int k, logic [31:0] w, int sh,
                              logic [31:0] e32, logic [11:0] e12, bit eir);
        string n;
        bit c32, c12;
        longint r;
        n = $sformatf("%s[%0d]", tag, k);
        chk({n, ".valid"}, longint'(v32 & v12), 1);
        chk({n, ".d32"}, longint'(d32), longint'(e32));
        chk({n, ".d12"}, longint'(d12), longint'(e12));
        chk({n, ".lane"}, longint'(lane32), longint'(k));
        chk({n, ".lane12"}, longint'(lane12), longint'(k));
        chk({n, ".last"}, longint'(last32), longint'(k == 3));
        chk({n, ".in_ready"}, longint'(rdy32), longint'(eir));
        chk_sat(n);
        r = ref_lane(32, w[k*8 +: 8], sh, c32);
        r = ref_lane(12, w[k*8 +: 8], sh, c12);
        if (out_ready) begin
            se32 |= c32;
            se12 |= c12;
        end
    endtask

    initial begin
        bit pend;
        bit c;
        exp_t e;
        int sh;

        tv[0] = '{32'h807FFF01, 5'd0,
                  {32'hFFFFFF80, 32'd127, 32'hFFFFFFFF, 32'd1},
                  {12'hF80, 12'd127, 12'hFFF, 12'd1}};
        tv[1] = '{32'h807FFF01, 5'd3,
                  {32'hFFFFFC00, 32'd1016, 32'hFFFFFFF8, 32'd8},
                  {12'hC00, 12'd1016, 12'hFF8, 12'd8}};
        tv[2] = '{32'h0000807F, 5'd5,
                  {32'd0, 32'd0, 32'hFFFFF000, 32'd4064},
                  {12'd0, 12'd0, 12'h800, 12'h7FF}};
        tv[3] = '{32'hFF017F80, 5'd31,
                  {32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000},
                  {12'h800, 12'h7FF, 12'h7FF, 12'h800}};
        tv[4] = '{32'h00000000, 5'd31,
                  {32'd0, 32'd0, 32'd0, 32'd0},
                  {12'd0, 12'd0, 12'd0, 12'd0}};
        tv[5] = '{32'h40C0017F, 5'd24,
                  {32'h40000000, 32'hC0000000, 32'h01000000, 32'h7F000000},
                  {12'h7FF, 12'h800, 12'h7FF, 12'h7FF}};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        in_shift = '0;
        se32 = 1'b0;
        se12 = 1'b0;
        #3;
        chk("rst.valid", longint'(v32 | v12), 0);
        chk("rst.in_ready", longint'(rdy32 | rdy12), 0);
        chk("rst.d32", longint'(d32), 0);
        chk("rst.d12", longint'(d12), 0);
        chk("rst.lane", longint'(lane32), 0);
        chk("rst.last", longint'(last32), 0);
        chk_sat("rst");
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle.in_ready", longint'(rdy32 & rdy12), 1);

        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = tv[i].data;
            in_shift = tv[i].sh;
            out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            in_shift = 5'd17;
            for (int k = 0; k < 4; k++) begin
                check_beat($sformatf("vec%0d", i), k, tv[i].data, int'(tv[i].sh),
                           tv[i].e32[k], tv[i].e12[k], k == 3);
                step();
            end
            chk($sformatf("vec%0d.idle", i), longint'(v32), 0);
            chk_sat($sformatf("vec%0d.end", i));
        end

        in_valid = 1'b1;
        in_data = tv[0].data;
        in_shift = tv[0].sh;
        step();
        in_valid = 1'b0;
        check_beat("bp", 0, tv[0].data, 0, tv[0].e32[0], tv[0].e12[0], 0);
        step();
        check_beat("bp", 1, tv[0].data, 0, tv[0].e32[1], tv[0].e12[1], 0);
        step();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = tv[1].data;
        for (int s = 0; s < 3; s++) begin
            check_beat("bp_hold", 2, tv[0].data, 0, tv[0].e32[2], tv[0].e12[2], 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_beat("bp", 2, tv[0].data, 0, tv[0].e32[2], tv[0].e12[2], 0);
        step();
        check_beat("bp", 3, tv[0].data, 0, tv[0].e32[3], tv[0].e12[3], 1);
        step();
        chk("bp.idle", longint'(v32), 0);

        in_valid = 1'b1;
        in_data = tv[0].data;
        in_shift = tv[0].sh;
        step();
        in_data = tv[2].data;
        in_shift = tv[2].sh;
        for (int b = 0; b < 8; b++) begin
            if (b < 4)
                check_beat("b2b_a", b, tv[0].data, 0, tv[0].e32[b], tv[0].e12[b], b == 3);
            else
                check_beat("b2b_b", b - 4, tv[2].data, 5,
                           tv[2].e32[b-4], tv[2].e12[b-4], b == 7);
            if (b == 4) in_valid = 1'b0;
            step();
        end
        chk("b2b.idle", longint'(v32), 0);

        in_valid = 1'b1;
        in_data = tv[1].data;
        in_shift = tv[1].sh;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", longint'(v32 | v12), 0);
        chk("arst.in_ready", longint'(rdy32 | rdy12), 0);
        chk("arst.d32", longint'(d32), 0);
        se32 = 1'b0;
        se12 = 1'b0;
        chk_sat("arst");
        step();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("arst.rel_ready", longint'(rdy32), 1);
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("arst.noemit%0d", s), longint'(v32 | v12), 0);
            step();
        end

        pend = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data = $urandom;
                if ($urandom_range(0, 3) == 0) in_data[15:8] = 8'h80;
                in_shift = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 6))
                                                       : 5'($urandom_range(0, 31));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #3;
            chk_sat("rnd");
            if (v32) begin
                if (q.size() == 0) begin
                    chk("rnd.spurious_beat", 1, 0);
                end else begin
                    e = q[0];
                    chk("rnd.d32", longint'(signed'(d32)), e.a);
                    chk("rnd.d12", longint'(signed'(d12)), e.b);
                    chk("rnd.lane", longint'(lane32), longint'(e.lane));
                    chk("rnd.last", longint'(last32), longint'(e.lane == 3));
                    if (out_ready) begin
                        void'(q.pop_front());
                        se32 |= e.ca;
                        se12 |= e.cb;
                    end
                end
            end
            if (in_valid && rdy32) begin
                sh = int'(in_shift);
                for (int k = 0; k < 4; k++) begin
                    e.lane = k;
                    e.a = ref_lane(32, in_data[k*8 +: 8], sh, c);
                    e.ca = c;
                    e.b = ref_lane(12, in_data[k*8 +: 8], sh, c);
                    e.cb = c;
                    q.push_back(e);
                end
                pend = 1'b0;
            end else begin
                pend = in_valid;
            end
            step();
        end

        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (v32 && q.size() != 0) begin
                e = q.pop_front();
                chk("drain.d32", longint'(signed'(d32)), e.a);
                chk("drain.d12", longint'(signed'(d12)), e.b);
                se32 |= e.ca;
                se12 |= e.cb;
            end
            step();
        end
        chk("drain.empty", longint'(q.size()), 0);
        chk("drain.idle", longint'(v32), 0);
        chk_sat("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dequant_unpacker.md
Name: dequant_unpacker

Overview:
- Streaming widener for the addertree datapath; it undoes the narrowing done by the saturating clip stage.
- Accepts packed words of LANES signed TARGET_BW-bit values and emits them one lane per beat.
- Each lane is sign-extended to INPUT_BW, scaled by 2^in_shift, and saturated to the INPUT_BW signed range.
- Feeds the adder-tree input from quantized activation/weight storage.

Parameters:
- INPUT_BW, 32, wide (output) signed width.
- TARGET_BW, 8, narrow (packed lane) signed width.
- LANES, 4, lanes per packed input word (>=2).
- SHIFT_W, 5, width of the per-word left-shift amount.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  packed word present.
- in_ready  output  1  block accepts word this cycle.
- in_data  input  LANES*TARGET_BW  packed signed lanes; lane k = bits [k*TARGET_BW +: TARGET_BW].
- in_shift  input  SHIFT_W  left-shift amount, captured with the word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  INPUT_BW  signed widened, scaled, saturated lane.
- out_lane  output  clog2(LANES)  index of lane on out_data.
- out_last  output  1  high on the beat carrying lane LANES-1.

Behaviour:
- Reset state: word buffer and shift register cleared, lane counter 0, state IDLE.
- Outputs during rst: out_valid=0, in_ready=0, out_data=0, out_lane=0, out_last=0.
- States: IDLE and EMIT.
- IDLE:
  - in_ready=1.
  - When in_valid & in_ready, register in_data and in_shift, set lane=0, go to EMIT.
- EMIT:
  - out_valid=1.
  - Each cycle with out_ready=1 the lane advances.
  - On the last lane with out_ready=1: if in_valid=1, the next word is loaded in the same cycle (lane=0, stay in EMIT); otherwise go to IDLE.
- in_ready = IDLE, or (EMIT & lane==LANES-1 & out_ready).
  - This gives zero-bubble back-to-back operation: sustained throughput is 1 beat/cycle, 1 word per LANES cycles.
- Latency: word accepted at edge N; lane 0 appears on out_data after edge N (cycle N+1).
- Lane order: lane 0 first, lane LANES-1 last. out_last = (lane==LANES-1) & out_valid.
- Backpressure: while out_valid & ~out_ready, out_data, out_lane and out_last are held stable; out_valid never drops without a handshake.
- Arithmetic:
  - v = sign-extended lane; r = v * 2^in_shift, computed exactly (no overflow in the intermediate).
  - If r > 2^(INPUT_BW-1)-1, out_data = 2^(INPUT_BW-1)-1.
  - Else if r < -2^(INPUT_BW-1), out_data = -2^(INPUT_BW-1).
  - Else out_data = r.
  - A zero lane always yields 0, for any shift.
- out_data is a registered value or a pure function of registered state (buffer, shift, lane). There are no combinational paths from in_* to out_*.
- in_shift is sampled only on acceptance; changes mid-word have no effect.
- Reset mid-word: outputs clear immediately (asynchronous). Remaining lanes are discarded and are not emitted after release.
- in_valid while not ready: the word is not consumed. The upstream must hold it (standard valid/ready).

Optional Feature:
- Macro: DEQUANT_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_seen (1 bit).
  - Sticky; set on the cycle after any handshaked beat whose value was clamped.
  - Cleared only by rst.
- Undefined:
  - Port absent, no flag logic.
  - Saturation arithmetic is identical.

Test Plan:
1. Defaults; in_data=0x807FFF01, shift=0, out_ready=1 -> out_data 1, -1, 127, -128 on 4 consecutive cycles starting N+1; out_lane 0..3; out_last only on the 4th beat.
2. Same word, shift=3 -> 8, -8, 1016, -1024; sat_seen stays 0.
3. INPUT_BW=12 instance, in_data=0x0000807F, shift=5:
   - 127*32 -> 2047 (clamped); 0x80 -> -2048 (clamped); lanes 2 and 3 -> 0.
   - With DEQUANT_SAT_FLAG_EN, sat_seen=1 after the first beat and stays 1.
4. Hold out_ready=0 for 3 cycles while lane 2 is presented -> out_data, out_lane=2 and out_valid=1 are stable; in_ready=0; lane 3 follows the first ready cycle.
5. Two words back-to-back, in_valid held high, out_ready=1 -> 8 beats in 8 consecutive cycles with no gap; in_ready pulses high only in the cycle of lane 3 of the first word.
6. Assert rst asynchronously after lane 1 handshakes -> out_valid=0 and in_ready=0 immediately; after release in_ready=1, out_valid=0, and lanes 2 and 3 are never emitted.
